// File: rtl/ddr_init_seq.sv
// DDR4 power-up sequencer: reset hold, CKE, MR3/6/5/4/2/1/0 programming, ZQCL, then init_done.
// Define DDR_REF_GEN_EN to add the periodic refresh generator that runs once init_done is set.
module ddr_init_seq #(
  parameter int          RST_CYC = 20,
  parameter int          CKE_DLY = 50,
  parameter int          tIS     = 2,
  parameter int          tXPR    = 24,
  parameter int          tMRD    = 8,
  parameter int          tMOD    = 24,
  parameter int          tZQ     = 512,
  parameter int          tREF    = 780,
  parameter logic [13:0] MR0_VAL = 14'd0,
  parameter logic [13:0] MR1_VAL = 14'd0,
  parameter logic [13:0] MR2_VAL = 14'd0,
  parameter logic [13:0] MR3_VAL = 14'd0,
  parameter logic [13:0] MR4_VAL = 14'd0,
  parameter logic [13:0] MR5_VAL = 14'd0,
  parameter logic [13:0] MR6_VAL = 14'd0
) (
  input  logic        clock_t,
  input  logic        reset_n,
  input  logic        cmd_busy,
  output logic        ddr_reset_n,
  output logic        cke,
  output logic        cs_n,
  output logic        act_n,
  output logic        ras_n_a16,
  output logic        cas_n_a15,
  output logic        we_n_a14,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic [13:0] addr,
  output logic        init_done,
  output logic        ref_forced
);

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_WAIT = maxOf(maxOf(maxOf(RST_CYC - 1, CKE_DLY - 1), maxOf(tIS + tXPR - 1, tMRD - 1)),
                                  maxOf(maxOf(tMOD - 1, tZQ - 1), tREF));
  localparam int CW = $clog2(MAX_WAIT + 2);

  // A load of N-1 makes the next action land N cycles after the loading cycle.
  localparam logic [CW-1:0] LD_RST   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] LD_CKE   = CW'(CKE_DLY - 1);
  localparam logic [CW-1:0] LD_XPR   = CW'(tIS + tXPR - 1);
  localparam logic [CW-1:0] LD_MRD   = CW'(tMRD - 1);
  localparam logic [CW-1:0] LD_MOD   = CW'(tMOD - 1);
  localparam logic [CW-1:0] LD_ZQ    = CW'(tZQ - 1);
  localparam logic [CW-1:0] LD_REF1  = CW'(tREF - 1);
`ifdef DDR_REF_GEN_EN
  localparam logic [CW-1:0] LD_REF   = CW'(tREF);
`endif

  typedef enum logic [2:0] {
    RST_HOLD, CKE_WAIT, XPR_WAIT, MRS, MOD_WAIT, ZQCL, ZQ_WAIT, DONE
  } state_e;

  function automatic logic [2:0] mrNum(input logic [2:0] step);
    case (step)
      3'd0:    return 3'd3;
      3'd1:    return 3'd6;
      3'd2:    return 3'd5;
      3'd3:    return 3'd4;
      3'd4:    return 3'd2;
      3'd5:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [13:0] mrVal(input logic [2:0] mr);
    case (mr)
      3'd0:    return MR0_VAL;
      3'd1:    return MR1_VAL;
      3'd2:    return MR2_VAL;
      3'd3:    return MR3_VAL;
      3'd4:    return MR4_VAL;
      3'd5:    return MR5_VAL;
      3'd6:    return MR6_VAL;
      default: return 14'd0;
    endcase
  endfunction

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      mrStep_q;
  logic            ddrResetN_q, cke_q, initDone_q, refForced_q;
  logic            csN_q, actN_q, rasN_q, casN_q, weN_q;
  logic [1:0]      bg_q, ba_q;
  logic [13:0]     addr_q;
  logic [2:0]      mrSel;
`ifdef DDR_REF_GEN_EN
  logic [1:0]      dueAge_q;
`else
  logic            unusedBusy;
  assign unusedBusy = cmd_busy;
`endif

  assign mrSel = mrNum(mrStep_q);

  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      state_q     <= RST_HOLD;
      cnt_q       <= LD_RST;
      mrStep_q    <= 3'd0;
      ddrResetN_q <= 1'b0;
      cke_q       <= 1'b0;
      initDone_q  <= 1'b0;
      refForced_q <= 1'b0;
      csN_q       <= 1'b1;
      actN_q      <= 1'b1;
      rasN_q      <= 1'b1;
      casN_q      <= 1'b1;
      weN_q       <= 1'b1;
      bg_q        <= 2'd0;
      ba_q        <= 2'd0;
      addr_q      <= 14'd0;
`ifdef DDR_REF_GEN_EN
      dueAge_q    <= 2'd0;
`endif
    end else begin
      // Deselect unless a state below issues a command this cycle; the counter saturates at 0.
      csN_q       <= 1'b1;
      actN_q      <= 1'b1;
      rasN_q      <= 1'b1;
      casN_q      <= 1'b1;
      weN_q       <= 1'b1;
      bg_q        <= 2'd0;
      ba_q        <= 2'd0;
      addr_q      <= 14'd0;
      refForced_q <= 1'b0;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;

      case (state_q)
        RST_HOLD: if (cnt_q == '0) begin
          ddrResetN_q <= 1'b1;
          cnt_q       <= LD_CKE;
          state_q     <= CKE_WAIT;
        end
        CKE_WAIT: if (cnt_q == '0) begin
          cke_q   <= 1'b1;
          cnt_q   <= LD_XPR;
          state_q <= XPR_WAIT;
        end
        XPR_WAIT, MRS: if (cnt_q == '0) begin
          csN_q  <= 1'b0;
          rasN_q <= 1'b0;
          casN_q <= 1'b0;
          weN_q  <= 1'b0;
          bg_q   <= {1'b0, mrSel[2]};
          ba_q   <= mrSel[1:0];
          addr_q <= mrVal(mrSel);
          if (mrStep_q == 3'd6) begin
            mrStep_q <= 3'd0;
            cnt_q    <= LD_MOD;
            state_q  <= MOD_WAIT;
          end else begin
            mrStep_q <= mrStep_q + 3'd1;
            cnt_q    <= LD_MRD;
            state_q  <= MRS;
          end
        end
        MOD_WAIT: if (cnt_q == '0) begin
          // A10 high selects long calibration.
          csN_q   <= 1'b0;
          weN_q   <= 1'b0;
          addr_q  <= 14'h0400;
          state_q <= ZQCL;
        end
        ZQCL: begin
          cnt_q   <= LD_ZQ;
          state_q <= ZQ_WAIT;
        end
        ZQ_WAIT: if (cnt_q == '0) begin
          initDone_q <= 1'b1;
          cnt_q      <= LD_REF1;
          state_q    <= DONE;
        end
        DONE: begin
`ifdef DDR_REF_GEN_EN
          // A due refresh waits for an idle command path, but at most three cycles.
          if (cnt_q == '0) begin
            if (!cmd_busy || dueAge_q == 2'd3) begin
              csN_q       <= 1'b0;
              rasN_q      <= 1'b0;
              casN_q      <= 1'b0;
              refForced_q <= cmd_busy;
              cnt_q       <= LD_REF;
              dueAge_q    <= 2'd0;
            end else begin
              dueAge_q <= dueAge_q + 2'd1;
            end
          end
`endif
        end
        default: state_q <= RST_HOLD;
      endcase
    end
  end

  assign ddr_reset_n = ddrResetN_q;
  assign cke         = cke_q;
  assign cs_n        = csN_q;
  assign act_n       = actN_q;
  assign ras_n_a16   = rasN_q;
  assign cas_n_a15   = casN_q;
  assign we_n_a14    = weN_q;
  assign bg_addr     = bg_q;
  assign ba_addr     = ba_q;
  assign addr        = addr_q;
  assign init_done   = initDone_q;
  assign ref_forced  = refForced_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Scoreboard bench for ddr_init_seq: expected pin events are queued before each run and popped as the DUT emits them.
// Refresh expectations are only queued when DDR_REF_GEN_EN is defined.
module tb_ddr_init_seq;

  localparam int EV_RSTN = 1, EV_CKE = 2, EV_MRS = 3, EV_ZQCL = 4, EV_INIT = 5, EV_REF = 6, EV_BAD = 7;
  localparam logic [13:0] MRV [7] = '{14'h01A5, 14'h00B2, 14'h03C3, 14'h02D4, 14'h15E5, 14'h06F6, 14'h3707};

  typedef struct {
    int cyc;
    int kind;
    int mr;
    bit forced;
  } expEv_t;

  logic        clock_t = 1'b0;
  logic        reset_n, cmd_busy;
  logic        ddr_reset_n, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
  logic [1:0]  bg_addr, ba_addr;
  logic [13:0] addr;
  logic        init_done, ref_forced;

  int     cyc = 0;
  int     evalCount = 0;
  int     failCount = 0;
  bit     monitorOn = 1'b0;
  logic   prevRstN = 1'b0, prevCke = 1'b0, prevInit = 1'b0;
  expEv_t expQ[$];

  ddr_init_seq #(
    .MR0_VAL(MRV[0]), .MR1_VAL(MRV[1]), .MR2_VAL(MRV[2]), .MR3_VAL(MRV[3]),
    .MR4_VAL(MRV[4]), .MR5_VAL(MRV[5]), .MR6_VAL(MRV[6])
  ) dut (
    .clock_t(clock_t), .reset_n(reset_n), .cmd_busy(cmd_busy),
    .ddr_reset_n(ddr_reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .addr(addr),
    .init_done(init_done), .ref_forced(ref_forced)
  );

  always #5 clock_t = ~clock_t;

  // Cycle k is the output period after the k-th rising edge that sampled reset_n high.
  always @(posedge clock_t) begin
    if (!reset_n) cyc = 0;
    else cyc = cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic pushEv(input int c, input int k, input int m, input bit f);
    expEv_t e;
    e.cyc = c; e.kind = k; e.mr = m; e.forced = f;
    expQ.push_back(e);
  endtask

  task automatic pushInit(input int limit);
    int mrsCyc [7] = '{96, 104, 112, 120, 128, 136, 144};
    int mrOrder [7] = '{3, 6, 5, 4, 2, 1, 0};
    if (20 < limit) pushEv(20, EV_RSTN, 0, 1'b0);
    if (70 < limit) pushEv(70, EV_CKE, 0, 1'b0);
    for (int i = 0; i < 7; i++)
      if (mrsCyc[i] < limit) pushEv(mrsCyc[i], EV_MRS, mrOrder[i], 1'b0);
    if (168 < limit) pushEv(168, EV_ZQCL, 0, 1'b0);
    if (681 < limit) pushEv(681, EV_INIT, 0, 1'b0);
  endtask

  task automatic handleEvent(input int kind);
    expEv_t e;
    logic [2:0] mrBits;
    checkOutput($sformatf("event %0d expected", kind), {31'd0, expQ.size() != 0}, 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      mrBits = 3'(e.mr);
      checkOutput("event kind", kind, e.kind);
      checkOutput($sformatf("cycle of event %0d", kind), cyc, e.cyc);
      if (kind == EV_MRS && e.kind == EV_MRS) begin
        checkOutput($sformatf("MR%0d bg_addr", e.mr), {30'd0, bg_addr}, {31'd0, mrBits[2]});
        checkOutput($sformatf("MR%0d ba_addr", e.mr), {30'd0, ba_addr}, {30'd0, mrBits[1:0]});
        checkOutput($sformatf("MR%0d addr", e.mr), {18'd0, addr}, {18'd0, MRV[e.mr]});
      end
      if (kind == EV_REF && e.kind == EV_REF)
        checkOutput("ref_forced on REF", {31'd0, ref_forced}, {31'd0, e.forced});
    end
  endtask

  always @(negedge clock_t) begin
    int kind;
    if (monitorOn) begin
      if (ddr_reset_n === 1'b1 && prevRstN === 1'b0) handleEvent(EV_RSTN);
      if (cke === 1'b1 && prevCke === 1'b0) handleEvent(EV_CKE);
      if (init_done === 1'b1 && prevInit === 1'b0) handleEvent(EV_INIT);
      if (cyc != 0 && prevCke === 1'b1) checkOutput("cke held", {31'd0, cke}, 32'd1);
      if (cyc != 0 && prevInit === 1'b1) checkOutput("init_done held", {31'd0, init_done}, 32'd1);
      if (cs_n === 1'b0) begin
        kind = EV_BAD;
        if ({act_n, ras_n_a16, cas_n_a15, we_n_a14} === 4'b1000) kind = EV_MRS;
        if ({act_n, ras_n_a16, cas_n_a15, we_n_a14} === 4'b1110) kind = EV_ZQCL;
        if ({act_n, ras_n_a16, cas_n_a15, we_n_a14} === 4'b1001) kind = EV_REF;
        handleEvent(kind);
        if (kind != EV_REF) checkOutput("ref_forced idle", {31'd0, ref_forced}, 32'd0);
      end else begin
        checkOutput("deselect pins", {10'd0, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg_addr, ba_addr, addr},
                    {10'd0, 4'hF, 18'd0});
        checkOutput("ref_forced idle", {31'd0, ref_forced}, 32'd0);
      end
    end
    prevRstN = ddr_reset_n;
    prevCke  = cke;
    prevInit = init_done;
  end

  task automatic checkResetOutputs();
    checkOutput("reset ddr_reset_n", {31'd0, ddr_reset_n}, 32'd0);
    checkOutput("reset cke", {31'd0, cke}, 32'd0);
    checkOutput("reset cmd pins", {27'd0, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}, 32'h1F);
    checkOutput("reset bg/ba", {28'd0, bg_addr, ba_addr}, 32'd0);
    checkOutput("reset addr", {18'd0, addr}, 32'd0);
    checkOutput("reset init_done", {31'd0, init_done}, 32'd0);
    checkOutput("reset ref_forced", {31'd0, ref_forced}, 32'd0);
  endtask

  // Holds reset_n low for three rising edges, checking outputs after the first, then releases it.
  task automatic applyReset();
    reset_n = 1'b0;
    @(negedge clock_t);
    checkResetOutputs();
    repeat (2) @(negedge clock_t);
    reset_n = 1'b1;
  endtask

  // Runs until cycle endCyc; cmd_busy is high for the edges busyOn .. busyOff-1.
  task automatic applyStimulus(input int endCyc, input int busyOn, input int busyOff);
    while (cyc < endCyc) begin
      cmd_busy = (cyc + 1 >= busyOn) && (cyc + 1 < busyOff);
      @(negedge clock_t);
    end
    cmd_busy = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    cmd_busy = 1'b0;
    $display("[TB] reset and default sequence, idle command path");
    @(negedge clock_t);
    monitorOn = 1'b1;
    pushInit(1 << 30);
`ifdef DDR_REF_GEN_EN
    pushEv(1461, EV_REF, 0, 1'b0);
    pushEv(2242, EV_REF, 0, 1'b0);
    pushEv(3023, EV_REF, 0, 1'b0);
`endif
    applyReset();
    applyStimulus(3030, 0, 0);
    checkOutput("run A events drained", expQ.size(), 0);

    $display("[TB] cmd_busy on edges 2242-2243");
    pushInit(1 << 30);
`ifdef DDR_REF_GEN_EN
    pushEv(1461, EV_REF, 0, 1'b0);
    pushEv(2244, EV_REF, 0, 1'b0);
    pushEv(3025, EV_REF, 0, 1'b0);
`endif
    applyReset();
    applyStimulus(3030, 2242, 2244);
    checkOutput("run B events drained", expQ.size(), 0);

    $display("[TB] cmd_busy held from edge 2242");
    pushInit(1 << 30);
`ifdef DDR_REF_GEN_EN
    pushEv(1461, EV_REF, 0, 1'b0);
    pushEv(2245, EV_REF, 0, 1'b1);
    pushEv(3026, EV_REF, 0, 1'b0);
`endif
    applyReset();
    applyStimulus(3030, 2242, 2246);
    checkOutput("run C events drained", expQ.size(), 0);

    $display("[TB] reset asserted at cycle 110 for three cycles");
    pushInit(110);
    applyReset();
    applyStimulus(109, 0, 0);
    checkOutput("run D pre-reset events drained", expQ.size(), 0);
    pushInit(1 << 30);
    applyReset();
    applyStimulus(700, 0, 0);
    checkOutput("run D replay events drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
    $finish;
  end

endmodule

// File: doc/ddr_init_seq.md
DDR_INIT_SEQ -- requirements
Module: ddr_init_seq

Interface
REQ-001 SHALL have parameter RST_CYC, default 20, meaning cycles ddr_reset_n is held low after reset release.
REQ-002 SHALL have parameter CKE_DLY, default 50, meaning cycles from ddr_reset_n rise to cke rise.
REQ-003 SHALL have parameters tIS=2, tXPR=24, tMRD=8, tMOD=24, tZQ=512, tREF=780, all in clock cycles and all ≥1.
REQ-004 SHALL have parameters MR0_VAL..MR6_VAL, 14 bits each, default 0, giving the mode-register opcodes driven on addr.
REQ-005 SHALL have port clock_t, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port cmd_busy, input, 1 bit: downstream command path busy; defers refresh.
REQ-008 SHALL have port ddr_reset_n, output, 1 bit: DRAM reset pin.
REQ-009 SHALL have port cke, output, 1 bit: clock enable.
REQ-010 SHALL have ports cs_n, act_n, ras_n_a16, cas_n_a15 and we_n_a14, outputs, 1 bit each: command pins.
REQ-011 SHALL have ports bg_addr and ba_addr, outputs, 2 bits each; and addr, output, 14 bits: the MR opcode.
REQ-012 SHALL have port init_done, output, 1 bit: sticky, set when the DRAM may accept ACT.
REQ-013 SHALL have port ref_forced, output, 1 bit: single-cycle pulse when a REF was issued while cmd_busy=1.

Function
REQ-014 SHALL drive the idle/deselect encoding on every cycle without a command: cs_n=act_n=ras=cas=we=1, bg_addr=ba_addr=0, addr=0.
REQ-015 SHALL make every command exactly one cycle wide, using registered outputs.
REQ-016 SHALL encode MRS as cs_n=0, act_n=1, ras=0, cas=0, we=0, with bg_addr[0]=MR[2] and ba_addr=MR[1:0], and addr=MRn_VAL.
REQ-017 SHALL encode ZQCL as cs_n=0, act_n=1, ras=1, cas=1, we=0.
REQ-018 SHALL encode REF as cs_n=0, act_n=1, ras=0, cas=0, we=1.
REQ-019 SHALL use FSM states RST_HOLD, CKE_WAIT, XPR_WAIT, MRS, MOD_WAIT, ZQCL, ZQ_WAIT, DONE.
REQ-020 SHALL number cycles from 0 = first cycle with reset_n=1, and make ddr_reset_n first high in cycle RST_CYC.
REQ-021 SHALL make cke first high in cycle C = RST_CYC + CKE_DLY, then keep it high until reset.
REQ-022 SHALL issue MRS in the order MR3, MR6, MR5, MR4, MR2, MR1, MR0.
REQ-023 SHALL issue MR3 in cycle C + tIS + tXPR, with consecutive MRS exactly tMRD cycles apart.
REQ-024 SHALL issue ZQCL exactly tMOD cycles after MR0.
REQ-025 SHALL first raise init_done in cycle Z + 1 + tZQ, where Z = ZQCL cycle, and hold it until reset.
REQ-026 SHALL use a single down-counter sized for the largest wait; it SHALL never wrap, saturating at 0.

Reset
REQ-027 SHALL, with reset_n=0 at a rising edge, on the next cycle output ddr_reset_n=0, cke=0, the deselect encoding, init_done=0 and ref_forced=0; FSM=RST_HOLD, counters cleared.
REQ-028 SHALL, on reset asserted mid-sequence (any state including DONE), abandon the sequence and restart it from cycle 0 after release.

Configuration
REQ-029 SHALL, when macro DDR_REF_GEN_EN is defined, include a refresh generator active only in DONE.
REQ-030 SHALL, with DDR_REF_GEN_EN, issue the first REF tREF cycles after init_done rises; later REFs are due tREF+1 cycles after the previous REF.
REQ-031 SHALL, with DDR_REF_GEN_EN, issue a due REF in the first cycle with cmd_busy=0.
REQ-032 SHALL, with DDR_REF_GEN_EN, issue the REF anyway if cmd_busy is still 1 at due+3, pulsing ref_forced in the same cycle.
REQ-033 SHALL measure each REF interval from the actual REF issue cycle.
REQ-034 SHALL, without DDR_REF_GEN_EN, never issue REF, ignore cmd_busy and tie ref_forced to 0.

Verification
REQ-035 SHALL cover: defaults, reset released at cycle 0 -> ddr_reset_n rises 20, cke rises 70, MR3/6/5/4/2/1/0 at 96/104/112/120/128/136/144, ZQCL 168, init_done 681.
REQ-036 SHALL cover: every MRS cycle -> bg_addr[0]/ba_addr match MR index, addr=MRn_VAL, no other command cycles before init_done.
REQ-037 SHALL cover: DDR_REF_GEN_EN, cmd_busy=0 -> REF at 1461, 2242, 3023.
REQ-038 SHALL cover: cmd_busy=1 for cycles 2242-2243 -> REF at 2244, next at 3025, ref_forced=0.
REQ-039 SHALL cover: cmd_busy=1 held from 2242 -> REF at 2245 with ref_forced=1 for that cycle only.
REQ-040 SHALL cover: reset_n=0 at cycle 110 for 3 cycles -> outputs at reset values next cycle, no MR4; sequence replays with MR3 at 96 cycles after release.
